imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory read-port arbiter between fetch and LSU literal reads.
// Define IMEM_ARB_RR_EN for round-robin; default is fetch priority + starvation guard.
module imem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_req_valid,
  output logic                  fetch_req_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_req_addr,
  output logic                  fetch_rsp_valid,
  output logic [DATA_WIDTH-1:0] fetch_rsp_data,
  input  logic                  fetch_flush,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  output logic                  lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rsp_data,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data
);

  logic       w_gnt_f;
  logic       w_gnt_l;
  logic       w_lsu_pri;
  logic       w_f_vld;
  logic       w_l_vld;
  logic [1:0] r_pend;

`ifdef IMEM_ARB_RR_EN
  logic r_last_lsu;

  assign w_lsu_pri = ~r_last_lsu;

  // Reset value means "LSU won last", so fetch takes the first contention.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_lsu <= 1'b1;
    end else if (w_gnt_f || w_gnt_l) begin
      r_last_lsu <= w_gnt_l;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;

  assign w_lsu_pri = (r_starve == LIMIT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (!lsu_req_valid || w_gnt_l) begin
      r_starve <= '0;
    end else if (r_starve != LIMIT) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`endif

  always_comb begin
    w_gnt_l = reset_n & lsu_req_valid
            & (~fetch_req_valid | w_lsu_pri);
    w_gnt_f = reset_n & fetch_req_valid & ~w_gnt_l;
  end

  assign fetch_req_ready = w_gnt_f;
  assign lsu_req_ready   = w_gnt_l;
  assign mem_enable      = w_gnt_f | w_gnt_l;

  always_comb begin
    mem_address = '0;
    if (w_gnt_l) begin
      mem_address = lsu_req_addr;
    end else if (w_gnt_f) begin
      mem_address = fetch_req_addr;
    end
  end

  // A flush in the grant cycle kills the fetch tag before it is stored.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend <= 2'b00;
    end else begin
      r_pend <= {w_gnt_f & ~fetch_flush, w_gnt_l};
    end
  end

  assign w_f_vld = reset_n & r_pend[1] & ~fetch_flush;
  assign w_l_vld = reset_n & r_pend[0];

  assign fetch_rsp_valid = w_f_vld;
  assign lsu_rsp_valid   = w_l_vld;
  assign fetch_rsp_data  = w_f_vld ? mem_data : '0;
  assign lsu_rsp_data    = w_l_vld ? mem_data : '0;

endmodule
